// File: rtl/mitm_segment_scheduler_if.sv
// Segment scheduler port bundle: sequence control, captured/injected SPI data and table programming.
// master = control FSM / programming side, slave = mitm_segment_scheduler.
interface mitm_segment_scheduler_if #(
    parameter int MAX_DATA_SIZE = 9,
    parameter int NUM_SEGMENTS  = 8
);
    localparam int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1);
    localparam int IDX_WIDTH       = $clog2(NUM_SEGMENTS + 1);

    logic                       mitm_start;
    logic                       eval;
    logic [MAX_DATA_SIZE-1:0]   real_miso_data;
    logic [MAX_DATA_SIZE-1:0]   real_mosi_data;
    logic [MAX_DATA_SIZE-1:0]   fake_miso_data;
    logic [MAX_DATA_SIZE-1:0]   fake_mosi_data;
    logic [DATA_SIZE_WIDTH-1:0] data_size;
    logic                       fake_miso_select;
    logic                       fake_mosi_select;
    logic                       eval_done;
    logic                       mitm_done;

    logic                       cfg_we;
    logic [IDX_WIDTH-1:0]       cfg_addr;
    logic [DATA_SIZE_WIDTH-1:0] cfg_size;
    logic [1:0]                 cfg_miso_mode;
    logic [1:0]                 cfg_mosi_mode;
    logic [MAX_DATA_SIZE-1:0]   cfg_miso_pat;
    logic [MAX_DATA_SIZE-1:0]   cfg_mosi_pat;
    logic                       cfg_match_en;
    logic [MAX_DATA_SIZE-1:0]   cfg_match_mask;
    logic [MAX_DATA_SIZE-1:0]   cfg_match_val;
    logic [IDX_WIDTH-1:0]       cfg_seg_count;
    logic                       cfg_busy;
    logic                       cfg_err;

    modport master (
        output mitm_start, eval, real_miso_data, real_mosi_data,
               cfg_we, cfg_addr, cfg_size, cfg_miso_mode, cfg_mosi_mode,
               cfg_miso_pat, cfg_mosi_pat, cfg_match_en, cfg_match_mask,
               cfg_match_val, cfg_seg_count,
        input  fake_miso_data, fake_mosi_data, data_size, fake_miso_select,
               fake_mosi_select, eval_done, mitm_done, cfg_busy, cfg_err
    );

    modport slave (
        input  mitm_start, eval, real_miso_data, real_mosi_data,
               cfg_we, cfg_addr, cfg_size, cfg_miso_mode, cfg_mosi_mode,
               cfg_miso_pat, cfg_mosi_pat, cfg_match_en, cfg_match_mask,
               cfg_match_val, cfg_seg_count,
        output fake_miso_data, fake_mosi_data, data_size, fake_miso_select,
               fake_mosi_select, eval_done, mitm_done, cfg_busy, cfg_err
    );
endinterface

// File: rtl/mitm_segment_scheduler.sv
// Table-driven MITM segment sequencer; eval->eval_done 3 cycles per segment, 1 on termination, eval outside ARMED dropped.
// Optional MOSI match/disarm logic is built only when MITM_SEGMENT_MATCH_EN is defined.
module mitm_segment_scheduler #(
    parameter int MAX_DATA_SIZE = 9,
    parameter int NUM_SEGMENTS  = 8
) (
    input logic                     sys_clk,
    input logic                     rst,
    mitm_segment_scheduler_if.slave bus
);
    localparam int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1);
    localparam int IDX_WIDTH       = $clog2(NUM_SEGMENTS + 1);
    localparam int AW              = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOAD, S_PRESENT, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_SIZE_WIDTH-1:0] size;
        logic [1:0]                 miso_mode;
        logic [1:0]                 mosi_mode;
        logic [MAX_DATA_SIZE-1:0]   miso_pat;
        logic [MAX_DATA_SIZE-1:0]   mosi_pat;
`ifdef MITM_SEGMENT_MATCH_EN
        logic                       match_en;
        logic [MAX_DATA_SIZE-1:0]   match_mask;
        logic [MAX_DATA_SIZE-1:0]   match_val;
`endif
    } entry_t;

    state_t                     state;
    entry_t                     tbl [NUM_SEGMENTS];
    entry_t                     rd;
    entry_t                     wr_entry;
    logic [IDX_WIDTH-1:0]       idx;
    logic [IDX_WIDTH-1:0]       count;
    logic                       armed;
    logic                       first_seg;
    logic                       wr_ok;
    logic [MAX_DATA_SIZE:0]     miso_nx;
    logic [MAX_DATA_SIZE:0]     mosi_nx;

    logic [DATA_SIZE_WIDTH-1:0] data_size_q;
    logic [MAX_DATA_SIZE-1:0]   fake_miso_q;
    logic [MAX_DATA_SIZE-1:0]   fake_mosi_q;
    logic                       miso_sel_q;
    logic                       mosi_sel_q;
    logic                       eval_done_q;
    logic                       mitm_done_q;
    logic                       cfg_err_q;

    assign first_seg = (idx == '0);
    assign bus.cfg_busy = (state == S_ARMED) || (state == S_LOAD) || (state == S_PRESENT);
    assign wr_ok = bus.cfg_we && !bus.cfg_busy
                && (bus.cfg_size != '0)
                && (bus.cfg_size <= DATA_SIZE_WIDTH'(MAX_DATA_SIZE))
                && (bus.cfg_addr < IDX_WIDTH'(NUM_SEGMENTS));

    // Returns {select, data} for one line; modes 0 and 3 pass the real traffic through.
    function automatic logic [MAX_DATA_SIZE:0] line_out(
        input logic [1:0]               mode,
        input logic [MAX_DATA_SIZE-1:0] pat,
        input logic [MAX_DATA_SIZE-1:0] prev,
        input logic                     first
    );
        logic [MAX_DATA_SIZE:0] r;
        r = '0;
        case (mode)
            2'd1:    r = {1'b1, pat};
            2'd2:    r = {1'b1, first ? {MAX_DATA_SIZE{1'b0}} : prev};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        miso_nx = '0;
        mosi_nx = '0;
        if (armed) begin
            miso_nx = line_out(rd.miso_mode, rd.miso_pat, bus.real_miso_data, first_seg);
            mosi_nx = line_out(rd.mosi_mode, rd.mosi_pat, bus.real_mosi_data, first_seg);
        end
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.size      = bus.cfg_size;
        wr_entry.miso_mode = bus.cfg_miso_mode;
        wr_entry.mosi_mode = bus.cfg_mosi_mode;
        wr_entry.miso_pat  = bus.cfg_miso_pat;
        wr_entry.mosi_pat  = bus.cfg_mosi_pat;
`ifdef MITM_SEGMENT_MATCH_EN
        wr_entry.match_en   = bus.cfg_match_en;
        wr_entry.match_mask = bus.cfg_match_mask;
        wr_entry.match_val  = bus.cfg_match_val;
`endif
    end

    // Table survives reset so a controller reset does not force reprogramming.
    always_ff @(posedge sys_clk) begin
        if (rst && wr_ok) begin
            tbl[bus.cfg_addr[AW-1:0]] <= wr_entry;
        end
    end

`ifndef MITM_SEGMENT_MATCH_EN
    logic unused_match;
    assign armed        = 1'b1;
    assign unused_match = ^{bus.cfg_match_en, bus.cfg_match_mask, bus.cfg_match_val};
`endif

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            count       <= '0;
            rd          <= '0;
            data_size_q <= '0;
            fake_miso_q <= '0;
            fake_mosi_q <= '0;
            miso_sel_q  <= 1'b0;
            mosi_sel_q  <= 1'b0;
            eval_done_q <= 1'b0;
            mitm_done_q <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef MITM_SEGMENT_MATCH_EN
            armed       <= 1'b1;
`endif
        end else begin
            eval_done_q <= 1'b0;
            cfg_err_q   <= bus.cfg_we && !wr_ok;
            if (bus.mitm_start) begin
                idx         <= '0;
                count       <= (bus.cfg_seg_count > IDX_WIDTH'(NUM_SEGMENTS)) ?
                               IDX_WIDTH'(NUM_SEGMENTS) : bus.cfg_seg_count;
                mitm_done_q <= 1'b0;
                state       <= S_ARMED;
`ifdef MITM_SEGMENT_MATCH_EN
                armed       <= 1'b1;
`endif
            end else begin
                case (state)
                    S_ARMED: if (bus.eval) begin
                        if (idx == count) begin
                            // Exhausted: nothing left to inject, so release the mux.
                            data_size_q <= '0;
                            fake_miso_q <= '0;
                            fake_mosi_q <= '0;
                            miso_sel_q  <= 1'b0;
                            mosi_sel_q  <= 1'b0;
                            mitm_done_q <= 1'b1;
                            eval_done_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            rd    <= tbl[idx[AW-1:0]];
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
`ifdef MITM_SEGMENT_MATCH_EN
                        if (!first_seg && rd.match_en &&
                            ((bus.real_mosi_data & rd.match_mask) != rd.match_val)) begin
                            armed <= 1'b0;
                        end
`endif
                        state <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        data_size_q <= rd.size;
                        miso_sel_q  <= miso_nx[MAX_DATA_SIZE];
                        fake_miso_q <= miso_nx[MAX_DATA_SIZE-1:0];
                        mosi_sel_q  <= mosi_nx[MAX_DATA_SIZE];
                        fake_mosi_q <= mosi_nx[MAX_DATA_SIZE-1:0];
                        eval_done_q <= 1'b1;
                        idx         <= idx + IDX_WIDTH'(1);
                        state       <= S_ARMED;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    assign bus.data_size        = data_size_q;
    assign bus.fake_miso_data   = fake_miso_q;
    assign bus.fake_mosi_data   = fake_mosi_q;
    assign bus.fake_miso_select = miso_sel_q;
    assign bus.fake_mosi_select = mosi_sel_q;
    assign bus.eval_done        = eval_done_q;
    assign bus.mitm_done        = mitm_done_q;
    assign bus.cfg_err          = cfg_err_q;
endmodule

// File: tb/tb_mitm_segment_scheduler.sv
// Directed + randomized bench for mitm_segment_scheduler against a segment-list reference model.
// Honours MITM_SEGMENT_MATCH_EN so the same bench covers both builds.
module tb_mitm_segment_scheduler;
    localparam int MD = 9;
    localparam int NS = 8;
    localparam int DW = 4;
    localparam int IW = 4;

    typedef struct {
        int size; int miso_mode; int mosi_mode; int miso_pat; int mosi_pat;
        int match_en; int mask; int val;
    } ent_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    ent_t tbl [NS];
    int   m_idx    = 0;
    int   m_count  = 0;
    bit   m_armed  = 1'b1;
    bit   m_active = 1'b0;

    mitm_segment_scheduler_if #(.MAX_DATA_SIZE(MD), .NUM_SEGMENTS(NS)) bus ();

    mitm_segment_scheduler #(.MAX_DATA_SIZE(MD), .NUM_SEGMENTS(NS)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Segment model: {select, data} packed as select*512 + data.
    function automatic int exp_line(input int mode, input int pat, input int prev, input bit first);
        if (!m_armed || !(mode == 1 || mode == 2)) return 0;
        if (mode == 1) return 512 + pat;
        return 512 + (first ? 0 : prev);
    endfunction

    task automatic cfg_write(input int addr, input int size, input int mim, input int mom,
                             input int mip, input int mop, input int men, input int mask, input int val);
        bit rej;
        rej = (size == 0) || (size > MD) || (addr >= NS) || m_active;
        bus.cfg_addr       = IW'(addr);
        bus.cfg_size       = DW'(size);
        bus.cfg_miso_mode  = 2'(mim);
        bus.cfg_mosi_mode  = 2'(mom);
        bus.cfg_miso_pat   = MD'(mip);
        bus.cfg_mosi_pat   = MD'(mop);
        bus.cfg_match_en   = 1'(men);
        bus.cfg_match_mask = MD'(mask);
        bus.cfg_match_val  = MD'(val);
        bus.cfg_we = 1'b1;
        tick();
        bus.cfg_we = 1'b0;
        chk("cfg_err", bus.cfg_err, rej);
        if (!rej) tbl[addr] = '{size, mim, mom, mip, mop, men, mask, val};
    endtask

    task automatic start_seq(input int c);
        bus.cfg_seg_count = IW'(c);
        bus.mitm_start = 1'b1;
        tick();
        bus.mitm_start = 1'b0;
        m_idx = 0; m_count = (c > NS) ? NS : c; m_armed = 1'b1; m_active = 1'b1;
        chk("busy_after_start", bus.cfg_busy, 1);
        chk("done_cleared", bus.mitm_done, 0);
    endtask

    task automatic run_eval(input string tag);
        int lat; bit term; ent_t e; int rmi; int rmo; int vmi; int vmo;
        term = (m_idx == m_count);
        rmi = int'(bus.real_miso_data);
        rmo = int'(bus.real_mosi_data);
        bus.eval = 1'b1;
        tick();
        bus.eval = 1'b0;
        lat = 1;
        while (bus.eval_done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, term ? 1 : 3);
        if (term) begin
            chk({tag, "_mitm_done"}, bus.mitm_done, 1);
            chk({tag, "_term_size"}, bus.data_size, 0);
            m_active = 1'b0;
        end else begin
            e = tbl[m_idx];
`ifdef MITM_SEGMENT_MATCH_EN
            if (m_idx != 0 && e.match_en != 0 && ((rmo & e.mask) != e.val)) m_armed = 1'b0;
`endif
            vmi = exp_line(e.miso_mode, e.miso_pat, rmi, m_idx == 0);
            vmo = exp_line(e.mosi_mode, e.mosi_pat, rmo, m_idx == 0);
            chk({tag, "_size"},     bus.data_size,        e.size);
            chk({tag, "_miso_sel"}, bus.fake_miso_select, vmi / 512);
            chk({tag, "_miso_dat"}, bus.fake_miso_data,   vmi % 512);
            chk({tag, "_mosi_sel"}, bus.fake_mosi_select, vmo / 512);
            chk({tag, "_mosi_dat"}, bus.fake_mosi_data,   vmo % 512);
            chk({tag, "_not_done"}, bus.mitm_done,        0);
            m_idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mitm_start = 0; bus.eval = 0; bus.real_miso_data = '0; bus.real_mosi_data = '0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_size = '0; bus.cfg_miso_mode = '0;
        bus.cfg_mosi_mode = '0; bus.cfg_miso_pat = '0; bus.cfg_mosi_pat = '0;
        bus.cfg_match_en = 0; bus.cfg_match_mask = '0; bus.cfg_match_val = '0;
        bus.cfg_seg_count = '0;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // Reset state
        chk("rst_size", bus.data_size, 0);
        chk("rst_miso_dat", bus.fake_miso_data, 0);
        chk("rst_mosi_dat", bus.fake_mosi_data, 0);
        chk("rst_sels", {bus.fake_miso_select, bus.fake_mosi_select}, 0);
        chk("rst_flags", {bus.eval_done, bus.mitm_done, bus.cfg_err}, 0);
        chk("rst_busy", bus.cfg_busy, 0);

        // Basic replace segment
        cfg_write(0, 8, 1, 0, 'h0A5, 0, 0, 0, 0);
        start_seq(1);
        run_eval("seg0");
        chk("direct_miso", bus.fake_miso_data, 'h0A5);
        tick();
        chk("eval_done_pulse", bus.eval_done, 0);
        chk("outputs_hold", bus.fake_miso_data, 'h0A5);
        run_eval("term1");
        bus.eval = 1'b1; tick(); bus.eval = 1'b0; tick();
        chk("eval_in_done_ignored", bus.eval_done, 0);
        chk("mitm_done_held", bus.mitm_done, 1);
        chk("busy_done", bus.cfg_busy, 0);

        // Rejected writes leave the table intact
        cfg_write(0, 0, 2, 2, 'h111, 'h111, 0, 0, 0);
        tick();
        chk("cfg_err_pulse", bus.cfg_err, 0);
        cfg_write(0, 10, 2, 2, 'h111, 'h111, 0, 0, 0);
        cfg_write(8, 5, 2, 2, 'h111, 'h111, 0, 0, 0);
        start_seq(1);
        cfg_write(0, 3, 2, 2, 'h111, 'h111, 0, 0, 0);
        run_eval("readback");
        run_eval("readback_term");

        // Echo from previous segment
        cfg_write(0, 9, 2, 2, 'h1F0, 'h0F1, 0, 0, 0);
        cfg_write(1, 5, 0, 2, 'h000, 'h000, 0, 0, 0);
        start_seq(2);
        bus.real_miso_data = 9'h1FF; bus.real_mosi_data = 9'h055;
        run_eval("echo0");
        bus.real_mosi_data = 9'h13C;
        run_eval("echo1");
        chk("echo_mosi_dat", bus.fake_mosi_data, 'h13C);
        chk("echo_mosi_sel", bus.fake_mosi_select, 1);
        run_eval("echo_term");

        // Match / disarm
        cfg_write(0, 4, 1, 1, 'h011, 'h022, 0, 0, 0);
        cfg_write(1, 6, 1, 1, 'h0AA, 'h033, 1, 'h0FF, 'h09F);
        cfg_write(2, 7, 1, 0, 'h044, 'h000, 0, 0, 0);
        start_seq(3);
        bus.real_mosi_data = 9'h000;
        run_eval("m0");
        bus.real_mosi_data = 9'h19E;
        run_eval("m1");
`ifdef MITM_SEGMENT_MATCH_EN
        chk("mismatch_sel", {bus.fake_miso_select, bus.fake_mosi_select}, 0);
`else
        chk("nomatch_sel", {bus.fake_miso_select, bus.fake_mosi_select}, 3);
`endif
        run_eval("m2");
        run_eval("m_term");
        start_seq(3);
        run_eval("p0");
        bus.real_mosi_data = 9'h09F;
        run_eval("p1");
        chk("match_sel", {bus.fake_miso_select, bus.fake_mosi_select}, 3);
        run_eval("p2");

        // mitm_start during PRESENT aborts and restarts
        start_seq(3);
        run_eval("r0");
        bus.eval = 1'b1; tick(); bus.eval = 1'b0; tick();
        bus.mitm_start = 1'b1; bus.eval = 1'b1; bus.cfg_seg_count = IW'(3);
        tick();
        bus.mitm_start = 1'b0; bus.eval = 1'b0;
        m_idx = 0; m_count = 3; m_armed = 1'b1; m_active = 1'b1;
        chk("abort_no_done", bus.eval_done, 0);
        run_eval("restart0");
        chk("restart_size", bus.data_size, 4);

        // Reset mid-LOAD aborts; table survives
        bus.eval = 1'b1; tick(); bus.eval = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1;
        m_active = 1'b0;
        chk("rst_abort_done", bus.eval_done, 0);
        chk("rst_abort_busy", bus.cfg_busy, 0);
        chk("rst_abort_size", bus.data_size, 0);
        start_seq(1);
        run_eval("post_rst");

        // Zero-length sequence
        start_seq(0);
        run_eval("count0");
        chk("count0_size", bus.data_size, 0);

        // Randomized sequences
        for (int a = 0; a < NS; a++)
            cfg_write(a, $urandom_range(1, MD), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 7));
        for (int it = 0; it < 20; it++) begin
            for (int w = 0; w < 3; w++)
                cfg_write($urandom_range(0, 9), $urandom_range(0, 11), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 511),
                          $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
            start_seq($urandom_range(0, 10));
            for (int s = 0; s < NS + 1 && m_active; s++) begin
                bus.real_miso_data = MD'($urandom_range(0, 511));
                bus.real_mosi_data = MD'($urandom_range(0, 511));
                if ($urandom_range(0, 3) == 0)
                    cfg_write($urandom_range(0, 7), 5, 1, 1, 1, 1, 0, 0, 0);
                run_eval("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mitm_segment_scheduler.md
# mitm_segment_scheduler

Table-driven sequencer that replaces the hand-written MITM logic behind the MITM control FSM. It stores a programmable list of SPI segments, each with a bit count, per-line injection mode and replacement pattern. On each `eval` it presents the next segment's `data_size`, fake data and line selects to the serial buffers and output mux. An optional per-segment MOSI match disarms injection when the observed traffic differs from what was expected.

## Interface
- `MAX_DATA_SIZE`, 9, max bits per segment; `DATA_SIZE_WIDTH` = $clog2(MAX_DATA_SIZE+1)
- `NUM_SEGMENTS`, 8, table depth; `IDX_WIDTH` = $clog2(NUM_SEGMENTS+1)
- `sys_clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset; synchronous, active-low
- `mitm_start`  in  1  pulse at SS rise: restart sequence
- `eval`  in  1  pulse: present next segment
- `real_miso_data`, `real_mosi_data`  in  MAX_DATA_SIZE  data captured in the last completed segment
- `fake_miso_data`, `fake_mosi_data`  out  MAX_DATA_SIZE  injected data
- `data_size`  out  DATA_SIZE_WIDTH  bit count of presented segment
- `fake_miso_select`, `fake_mosi_select`  out  1  mux selects (1 = inject)
- `eval_done`  out  1  one-cycle pulse: outputs valid
- `mitm_done`  out  1  level: sequence exhausted
- `cfg_we`  in  1  table write strobe
- `cfg_addr`  in  IDX_WIDTH  entry index
- `cfg_size`  in  DATA_SIZE_WIDTH; `cfg_miso_mode`, `cfg_mosi_mode`  in  2; `cfg_miso_pat`, `cfg_mosi_pat`, `cfg_match_mask`, `cfg_match_val`  in  MAX_DATA_SIZE; `cfg_match_en`  in  1
- `cfg_seg_count`  in  IDX_WIDTH  active entries, sampled on `mitm_start`
- `cfg_busy`  out  1  high outside IDLE/DONE
- `cfg_err`  out  1  one-cycle pulse: write rejected

## Operation
- States: IDLE, ARMED, LOAD, PRESENT, DONE.
- IDLE/DONE accept config writes.
  - A write is rejected, with a `cfg_err` pulse and the table unchanged, if any of these holds: `cfg_size` is 0, `cfg_size` > MAX_DATA_SIZE, `cfg_addr` ≥ NUM_SEGMENTS, or state is ARMED/LOAD/PRESENT.
- `mitm_start` in any state:
  - idx←0, count←min(`cfg_seg_count`, NUM_SEGMENTS), armed←1, `mitm_done`←0.
  - State → ARMED.
  - Wins over a simultaneous `eval`, which is dropped.
- ARMED + `eval`:
  - If idx == count: `mitm_done`←1, `eval_done` pulse, state → DONE.
  - Otherwise: registered table read of entry idx, state → LOAD.
- LOAD → PRESENT, unconditional.
  - Match check on the previous segment's `real_mosi_data`. If the entry has match_en=1 and (real_mosi & mask) ≠ val, then armed←0 permanently for this sequence.
  - The check is skipped for idx 0.
- PRESENT:
  - Drive outputs, pulse `eval_done`, idx←idx+1, state → ARMED.
  - Line modes: 0 = pass (select 0, data 0); 1 = replace (select 1, data = pattern); 2 = echo (select 1, data = previous segment's real data on the same line, 0 for idx 0); 3 = treated as pass.
  - If armed=0, both selects are 0 and both data buses are 0; `data_size` is still taken from the table.
- `eval` outside ARMED is ignored.
- Outputs hold their values between `eval_done` pulses.

## Timing
- Reset (`rst`=0 at a clock edge):
  - State IDLE; all outputs 0; idx/count 0; armed 1.
  - Table contents are unchanged by reset.
- Latency `eval` → `eval_done`: 3 cycles for a segment (ARMED, LOAD, PRESENT), 1 cycle for termination.
- `data_size`, data and selects change in the same cycle `eval_done` rises.
- `mitm_done` rises with the terminating `eval_done`. It is held until `mitm_start` or reset.
- `cfg_busy` is combinational from state.
- A reset or `mitm_start` arriving mid-LOAD/PRESENT aborts that segment with no `eval_done`.

## Configuration
- `MITM_SEGMENT_MATCH_EN` defined:
  - cfg_match_* fields are stored and the match/disarm logic is present.
- Not defined:
  - Match fields and logic are removed, so armed is constant 1 and every segment injects per its modes.
  - cfg_match_* inputs are ignored.

## Test plan
- Reset, then program entry 0 as size 8, MISO replace 0x0A5, MOSI pass; count=1. Then `mitm_start`, `eval` → after 3 cycles `eval_done`, data_size=8, fake_miso_data=0x0A5, miso_select=1, mosi_select=0. Next `eval` → `mitm_done`=1 one cycle later.
- Writes with cfg_size=0, cfg_size=10, and `cfg_we` while ARMED → `cfg_err` pulse each time; a readback sequence shows the old entries.
- Entry 1 MOSI echo, previous real_mosi_data=0x13C → segment 1 fake_mosi_data=0x13C, mosi_select=1.
- With the macro on, entry 1 has match mask 0x0FF, val 0x9F and real_mosi=0x19E → segment 1 and all later segments show selects 0. With real_mosi=0x09F the injection proceeds.
- `mitm_start` coincident with `eval` in PRESENT → no `eval_done`, idx restarts at 0.
- count=0 → first `eval` gives `eval_done` and `mitm_done` next cycle, with data_size=0.
